// File: rtl/tile_flip_controller.sv
// ---------------------------------------------------------------------------
// tile_flip_controller
//
// Game-play engine for a 16-tile memory game. It latches the board on load,
// accepts two tile selections per move, compares the two symbols and then
// either marks the pair matched or holds it face-up for SHOW_CYCLES cycles
// before flipping it back.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no board loaded; only load leaves
// WAIT_FIRST  | waiting for first tile of a pair (sel_ready=1)
// WAIT_SECOND | waiting for second tile of a pair (sel_ready=1)
// COMPARE     | one cycle: compare symbols, pulse match/mismatch
// SHOW        | mismatched pair held face-up while the timer runs down
// WON         | all tiles matched; only load or reset leaves
//
// Ports:
//   clk            system clock, rising-edge active
//   reset          asynchronous reset, active low
//   tile_setup     48-bit board, tile i symbol = tile_setup[3*i+2:3*i]
//   load           strobe: latch board, start new game
//   sel_valid      player selection valid
//   sel_idx        selected tile index
//   sel_ready      controller can accept a selection
//   face_up        per-tile shown flags
//   matched        per-tile matched flags
//   move_count     completed pair attempts, saturating at 255
//   match_pulse    one-cycle strobe on a matched pair
//   mismatch_pulse one-cycle strobe on a mismatched pair
//   game_won       high while in WON
// ---------------------------------------------------------------------------
module tile_flip_controller #(
   parameter int SHOW_CYCLES = 50_000_000,
   parameter int TIMER_W     = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] tile_setup,
   input  logic        load,
   input  logic        sel_valid,
   input  logic [3:0]  sel_idx,
   output logic        sel_ready,
   output logic [15:0] face_up,
   output logic [15:0] matched,
   output logic [7:0]  move_count,
   output logic        match_pulse,
   output logic        mismatch_pulse,
   output logic        game_won
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_FIRST  = 3'd1,
      WAIT_SECOND = 3'd2,
      COMPARE     = 3'd3,
      SHOW        = 3'd4,
      WON         = 3'd5
   } state_t;

   localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);

   state_t               r_state;
   logic [47:0]          r_board;
   logic [15:0]          r_face_up;
   logic [15:0]          r_matched;
   logic [7:0]           r_move_count;
   logic [3:0]           r_first_idx;
   logic [3:0]           r_second_idx;
   logic [TIMER_W-1:0]   r_timer;

   state_t               w_state_nxt;
   logic [47:0]          w_board_nxt;
   logic [15:0]          w_face_up_nxt;
   logic [15:0]          w_matched_nxt;
   logic [7:0]           w_move_count_nxt;
   logic [3:0]           w_first_idx_nxt;
   logic [3:0]           w_second_idx_nxt;
   logic [TIMER_W-1:0]   w_timer_nxt;

   logic [2:0]           w_sym [16];
   logic                 w_pair_eq;
   logic                 w_sel_ready;
   logic                 w_accept;
   logic [15:0]          w_pair_mask;

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_sym[i] = r_board[3*i +: 3];
      end
   end

   assign w_pair_eq   = (w_sym[r_first_idx] == w_sym[r_second_idx]);
   assign w_pair_mask = (16'h0001 << r_first_idx) | (16'h0001 << r_second_idx);
   assign w_sel_ready = (r_state == WAIT_FIRST) || (r_state == WAIT_SECOND);
   // Tiles already showing or already matched are silently ignored.
   assign w_accept    = sel_valid && w_sel_ready &&
                        !r_face_up[sel_idx] && !r_matched[sel_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_board      <= '0;
         r_face_up    <= '0;
         r_matched    <= '0;
         r_move_count <= '0;
         r_first_idx  <= '0;
         r_second_idx <= '0;
         r_timer      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_board      <= w_board_nxt;
         r_face_up    <= w_face_up_nxt;
         r_matched    <= w_matched_nxt;
         r_move_count <= w_move_count_nxt;
         r_first_idx  <= w_first_idx_nxt;
         r_second_idx <= w_second_idx_nxt;
         r_timer      <= w_timer_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_board_nxt      = r_board;
      w_face_up_nxt    = r_face_up;
      w_matched_nxt    = r_matched;
      w_move_count_nxt = r_move_count;
      w_first_idx_nxt  = r_first_idx;
      w_second_idx_nxt = r_second_idx;
      w_timer_nxt      = r_timer;

      if (load) begin
         // load wins over everything, including a same-cycle selection
         w_board_nxt      = tile_setup;
         w_face_up_nxt    = '0;
         w_matched_nxt    = '0;
         w_move_count_nxt = '0;
         w_timer_nxt      = '0;
         w_state_nxt      = WAIT_FIRST;
      end else begin
         case (r_state)
            WAIT_FIRST: begin
               if (w_accept) begin
                  w_face_up_nxt[sel_idx] = 1'b1;
                  w_first_idx_nxt        = sel_idx;
                  w_state_nxt            = WAIT_SECOND;
               end
            end
            WAIT_SECOND: begin
               if (w_accept) begin
                  w_face_up_nxt[sel_idx] = 1'b1;
                  w_second_idx_nxt       = sel_idx;
                  if (r_move_count != 8'hFF) begin
                     w_move_count_nxt = r_move_count + 8'd1;
                  end
                  w_state_nxt = COMPARE;
               end
            end
            COMPARE: begin
               if (w_pair_eq) begin
                  w_matched_nxt = r_matched | w_pair_mask;
                  w_state_nxt   = (w_matched_nxt == 16'hFFFF) ? WON : WAIT_FIRST;
               end else begin
                  w_timer_nxt = SHOW_LAST;
                  w_state_nxt = SHOW;
               end
            end
            SHOW: begin
               if (r_timer == '0) begin
                  w_face_up_nxt = r_face_up & ~w_pair_mask;
                  w_state_nxt   = WAIT_FIRST;
               end else begin
                  w_timer_nxt = r_timer - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sel_ready      = w_sel_ready;
   assign face_up        = r_face_up;
   assign matched        = r_matched;
   assign move_count     = r_move_count;
   assign match_pulse    = (r_state == COMPARE) &&  w_pair_eq;
   assign mismatch_pulse = (r_state == COMPARE) && !w_pair_eq;
   assign game_won       = (r_state == WON);

endmodule

// File: tb/tb_tile_flip_controller.sv
module tb_tile_flip_controller;

   logic        clk;
   logic        reset;
   logic [47:0] tile_setup;
   logic        load;
   logic        sel_valid;
   logic [3:0]  sel_idx;
   logic        sel_ready;
   logic [15:0] face_up;
   logic [15:0] matched;
   logic [7:0]  move_count;
   logic        match_pulse;
   logic        mismatch_pulse;
   logic        game_won;

   int n_checks = 0;
   int n_pass   = 0;

   logic [47:0] b0, b1, b2;

   tile_flip_controller #(.SHOW_CYCLES(4), .TIMER_W(26)) dut (
      .clk            (clk),
      .reset          (reset),
      .tile_setup     (tile_setup),
      .load           (load),
      .sel_valid      (sel_valid),
      .sel_idx        (sel_idx),
      .sel_ready      (sel_ready),
      .face_up        (face_up),
      .matched        (matched),
      .move_count     (move_count),
      .match_pulse    (match_pulse),
      .mismatch_pulse (mismatch_pulse),
      .game_won       (game_won)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // All tasks start and end just after a falling edge.
   task automatic pick(input int idx);
      sel_valid = 1'b1;
      sel_idx   = 4'(idx);
      @(negedge clk);
      sel_valid = 1'b0;
   endtask

   task automatic do_load(input logic [47:0] b);
      tile_setup = b;
      load       = 1'b1;
      @(negedge clk);
      load       = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!sel_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!sel_ready) check(tag, 32'(sel_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         b0[3*i +: 3] = 3'(7 - (i % 8));
         b1[3*i +: 3] = 3'(i % 8);
         b2[3*i +: 3] = 3'((i + 3) % 8);
      end
      reset = 1'b0; tile_setup = '0; load = 1'b0; sel_valid = 1'b0; sel_idx = '0;
      repeat (2) @(negedge clk);
      check("rst_ready",   32'(sel_ready), 0);
      check("rst_face",    32'(face_up), 0);
      check("rst_matched", 32'(matched), 0);
      check("rst_moves",   32'(move_count), 0);
      check("rst_pulses",  32'({match_pulse, mismatch_pulse, game_won}), 0);
      reset = 1'b1;
      @(negedge clk);
      pick(0);
      check("idle_ignore", 32'({sel_ready, face_up}), 0);

      // 1: matching pair 0/8
      do_load(b0);
      check("load_ready", 32'(sel_ready), 1);
      pick(0);
      check("t1_first_face", 32'(face_up), 32'h0001);
      pick(8);
      check("t1_match_pulse", 32'({match_pulse, mismatch_pulse}), 32'b10);
      check("t1_cmp_ready", 32'(sel_ready), 0);
      check("t1_moves", 32'(move_count), 1);
      @(negedge clk);
      check("t1_pulse_gone", 32'(match_pulse), 0);
      check("t1_matched", 32'(matched), 32'h0101);
      check("t1_face", 32'(face_up), 32'h0101);
      check("t1_ready", 32'(sel_ready), 1);

      // 2: mismatch 0/1 visible for 1+4 cycles; selections during SHOW ignored
      do_load(b0);
      pick(0);
      pick(1);
      check("t2_mismatch_pulse", 32'({match_pulse, mismatch_pulse}), 32'b01);
      check("t2_face0", 32'(face_up), 32'h0003);
      sel_valid = 1'b1; sel_idx = 4'd5;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("t2_face_held", 32'(face_up), 32'h0003);
         check("t2_show_flags", 32'({sel_ready, mismatch_pulse}), 0);
      end
      @(negedge clk);
      sel_valid = 1'b0;
      check("t2_face_cleared", 32'(face_up), 32'h0000);
      check("t2_ready", 32'(sel_ready), 1);
      check("t2_moves", 32'(move_count), 1);

      // 4: reselect and matched-tile selection ignored
      pick(0);
      pick(8);
      @(negedge clk);
      pick(3);
      check("t4_face", 32'(face_up), 32'h0109);
      pick(3);
      check("t4_same_ignored", 32'({sel_ready, face_up}), 32'h1_0109);
      pick(8);
      check("t4_matched_ignored", 32'({sel_ready, face_up}), 32'h1_0109);
      check("t4_moves", 32'(move_count), 2);
      pick(11);
      check("t4_match", 32'({match_pulse, move_count}), 32'h1_03);
      @(negedge clk);
      check("t4_matched", 32'(matched), 32'h0909);

      // 3: full game and WON
      do_load(b0);
      for (int i = 0; i < 8; i++) begin
         pick(i);
         pick(i + 8);
         check("t3_pair_match", 32'(match_pulse), 1);
         @(negedge clk);
      end
      check("t3_matched", 32'(matched), 32'hFFFF);
      check("t3_won", 32'({game_won, sel_ready}), 32'b10);
      check("t3_moves", 32'(move_count), 8);
      pick(4);
      @(negedge clk);
      check("t3_won_hold", 32'({game_won, face_up, move_count}), {7'd0, 1'b1, 16'hFFFF, 8'd8});
      do_load(b1);
      check("t3_reload", 32'({game_won, matched, face_up, move_count}), 0);
      check("t3_reload_ready", 32'(sel_ready), 1);

      // 5: load mid-SHOW, then async reset mid-SHOW
      pick(0);
      pick(1);
      check("t5_mismatch", 32'(mismatch_pulse), 1);
      repeat (2) @(negedge clk);
      do_load(b2);
      check("t5_load_clear", 32'({face_up, matched, move_count}), 0);
      check("t5_load_ready", 32'(sel_ready), 1);
      pick(0);
      pick(1);
      check("t5_mismatch2", 32'({mismatch_pulse, face_up}), 32'h1_0003);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t5_async_rst", 32'({face_up, move_count, sel_ready, mismatch_pulse}), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_idle", 32'(sel_ready), 0);

      // 6: move counter saturation, load drops same-cycle selection
      do_load(b0);
      for (int n = 1; n <= 260; n++) begin
         pick(0);
         pick(1);
         wait_ready("t6_timeout");
         if (n == 254) check("t6_moves_254", 32'(move_count), 254);
      end
      check("t6_saturated", 32'(move_count), 255);
      tile_setup = b0; load = 1'b1; sel_valid = 1'b1; sel_idx = 4'd2;
      @(negedge clk);
      load = 1'b0; sel_valid = 1'b0;
      check("t6_load_drops_sel", 32'({face_up, move_count}), 0);
      check("t6_ready", 32'(sel_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
